// File: rtl/mux_4_1.sv
// mux_4_1: registered 4:1 multiplexer with enable.
// One of four DATA_WIDTH-bit sources is chosen by a 2-bit select and
// registered to the output. Deasserting the enable forces a registered zero.
// The valid flag is a registered copy of the enable.
module mux_4_1 #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  Clock_In,
  input  logic                  Reset_N_In,
  input  logic                  Enable_In,
  input  logic [1:0]            Select_In,
  input  logic [DATA_WIDTH-1:0] Data_0_In,
  input  logic [DATA_WIDTH-1:0] Data_1_In,
  input  logic [DATA_WIDTH-1:0] Data_2_In,
  input  logic [DATA_WIDTH-1:0] Data_3_In,
  output logic [DATA_WIDTH-1:0] MUX_Data_Out,
  output logic                  MUX_Valid_Out
);

  logic [DATA_WIDTH-1:0] next_data;

  // Select the source for the next edge, or zero when disabled.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    next_data = '0;
    if (Enable_In) begin
      case (Select_In)
        2'd0:    next_data = Data_0_In;
        2'd1:    next_data = Data_1_In;
        2'd2:    next_data = Data_2_In;
        2'd3:    next_data = Data_3_In;
        // Only reachable with X/Z on the select in simulation; propagating
        // X makes an undriven select visible instead of masking it as zero.
        default: next_data = 'x;
      endcase
    end
  end

  // Output registers: asynchronous clear, one-cycle latency otherwise.
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!Reset_N_In) begin
      MUX_Data_Out  <= '0;
      MUX_Valid_Out <= 1'b0;
    end else begin
      MUX_Data_Out  <= next_data;
      MUX_Valid_Out <= Enable_In;
    end
  end

endmodule

// File: tb/tb_mux_4_1.sv
// Self-checking bench for mux_4_1. Two instances share clock, reset, enable
// and select: one at the default width of 1, one at width 8.
module tb_mux_4_1;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] select;
  logic [3:0] d_bits;
  logic [7:0] w [4];
  logic       out1;
  logic       valid1;
  logic [7:0] out8;
  logic       valid8;

  int check_count = 0;
  int pass_count  = 0;

  mux_4_1 u_dut1 (
    .Clock_In      (clk),
    .Reset_N_In    (rst_n),
    .Enable_In     (enable),
    .Select_In     (select),
    .Data_0_In     (d_bits[0]),
    .Data_1_In     (d_bits[1]),
    .Data_2_In     (d_bits[2]),
    .Data_3_In     (d_bits[3]),
    .MUX_Data_Out  (out1),
    .MUX_Valid_Out (valid1)
  );

  mux_4_1 #(.DATA_WIDTH(8)) u_dut8 (
    .Clock_In      (clk),
    .Reset_N_In    (rst_n),
    .Enable_In     (enable),
    .Select_In     (select),
    .Data_0_In     (w[0]),
    .Data_1_In     (w[1]),
    .Data_2_In     (w[2]),
    .Data_3_In     (w[3]),
    .MUX_Data_Out  (out8),
    .MUX_Valid_Out (valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'b1;
    select = 2'd2;
    d_bits = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_count++;
      if (out1 !== 1'b0 || valid1 !== 1'b0)
        $display("FAIL reset_hold[%0d]: got data=%b valid=%b required data=0 valid=0", i, out1, valid1);
      else pass_count++;
    end
    rst_n = 1'b1;
    tick();
    check_count++;
    if (out1 !== 1'b1 || valid1 !== 1'b1)
      $display("FAIL reset_release: got data=%b valid=%b required data=1 valid=1", out1, valid1);
    else pass_count++;
    // Assert reset between edges: outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_count++;
    if (out1 !== 1'b0 || valid1 !== 1'b0)
      $display("FAIL reset_async: got data=%b valid=%b required data=0 valid=0", out1, valid1);
    else pass_count++;
    #3;
    rst_n = 1'b1;
    tick();
    check_count++;
    if (out1 !== 1'b1 || valid1 !== 1'b1)
      $display("FAIL reset_rerelease: got data=%b valid=%b required data=1 valid=1", out1, valid1);
    else pass_count++;
  endtask

  task automatic test_disabled;
    enable = 1'b0;
    d_bits = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      tick();
      check_count++;
      if (out1 !== 1'b0 || valid1 !== 1'b0)
        $display("FAIL disabled[sel=%0d]: got data=%b valid=%b required data=0 valid=0", s, out1, valid1);
      else pass_count++;
    end
  endtask

  task automatic test_select_sweep;
    logic [3:0] expected;
    expected = 4'b0101;  // sel 0..3 -> 1,0,1,0
    enable = 1'b1;
    d_bits = 4'b0101;    // Data_0=1, Data_1=0, Data_2=1, Data_3=0
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      tick();
      check_count++;
      if (out1 !== expected[s] || valid1 !== 1'b1)
        $display("FAIL sweep[sel=%0d]: got data=%b valid=%b required data=%b valid=1", s, out1, valid1, expected[s]);
      else pass_count++;
    end
  endtask

  task automatic test_enable_toggle;
    logic [2:0] en_seq;
    logic [2:0] exp_seq;
    en_seq  = 3'b101;  // bit i = enable applied before edge i
    exp_seq = 3'b101;
    select = 2'd3;
    d_bits = 4'b1000;
    enable = 1'b1;
    tick();
    check_count++;
    if (out1 !== 1'b1 || valid1 !== 1'b1)
      $display("FAIL toggle_start: got data=%b valid=%b required data=1 valid=1", out1, valid1);
    else pass_count++;
    for (int i = 1; i < 3; i++) begin
      enable = en_seq[i];
      tick();
      check_count++;
      if (out1 !== exp_seq[i] || valid1 !== exp_seq[i])
        $display("FAIL toggle[%0d]: got data=%b valid=%b required data=%b valid=%b",
                 i, out1, valid1, exp_seq[i], exp_seq[i]);
      else pass_count++;
    end
  endtask

  task automatic test_random;
    logic       exp1;
    logic [7:0] exp8;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      select = 2'($urandom_range(0, 3));
      d_bits = 4'($urandom);
      for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
      exp1 = d_bits[select];
      exp8 = w[select];
      tick();
      check_count++;
      if (out1 !== exp1 || out8 !== exp8 || valid1 !== 1'b1 || valid8 !== 1'b1)
        $display("FAIL random[%0d]: got d1=%b d8=%h v=%b%b required d1=%b d8=%h v=11",
                 i, out1, out8, valid1, valid8, exp1, exp8);
      else pass_count++;
    end
  endtask

  task automatic test_width;
    enable = 1'b1;
    w[0] = 8'hA5;
    w[1] = 8'h3C;
    w[2] = 8'hFF;
    w[3] = 8'h00;
    select = 2'd1;
    tick();
    check_count++;
    if (out8 !== 8'h3C || valid8 !== 1'b1)
      $display("FAIL width_sel1: got data=%h valid=%b required data=3c valid=1", out8, valid8);
    else pass_count++;
    select = 2'd2;
    tick();
    check_count++;
    if (out8 !== 8'hFF || valid8 !== 1'b1)
      $display("FAIL width_sel2: got data=%h valid=%b required data=ff valid=1", out8, valid8);
    else pass_count++;
    // Input changes between edges must not reach the output.
    #2;
    select = 2'd0;
    w[2] = 8'h11;
    #1;
    check_count++;
    if (out8 !== 8'hFF)
      $display("FAIL width_between_edges: got data=%h required data=ff", out8);
    else pass_count++;
    tick();
    check_count++;
    if (out8 !== 8'hA5)
      $display("FAIL width_sel0: got data=%h required data=a5", out8);
    else pass_count++;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    select = 2'd0;
    d_bits = 4'b0000;
    for (int k = 0; k < 4; k++) w[k] = 8'h00;
    #2;
    test_reset();
    test_disabled();
    test_select_sweep();
    test_enable_toggle();
    test_random();
    test_width();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
